snax_tcdm_responder: RTL and testbench
======================================

SNAX_TCDM_RESPONDER -- requirements
Module: snax_tcdm_responder

Interface
REQ-001 SHALL have parameter DataWidth, default 64, word width in bits.
REQ-002 SHALL have parameter NumPorts, default 8, number of TCDM initiator ports served.
REQ-003 SHALL have parameter Depth, default 256, number of words stored (power of two).
REQ-004 SHALL have parameter TCDMAddrWidth, default 48, byte address width.
REQ-005 SHALL have parameter types tcdm_req_t and tcdm_rsp_t, default logic, using Snitch reqrsp TCDM fields q.{write,addr,amo,data,strb,user}, q_valid, q_ready, p.data, p_valid.
REQ-006 SHALL have clk_i  input  1  sole clock, rising edge.
REQ-007 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have tcdm_req_i  input  tcdm_req_t[NumPorts]  requests from initiators.
REQ-009 SHALL have tcdm_rsp_o  output  tcdm_rsp_t[NumPorts]  q_ready grant and read response per port.

Function
REQ-010 SHALL grant at most one request per cycle; q_ready[i] is combinational, asserted only when q_valid[i] is high and port i wins arbitration.
REQ-011 SHALL arbitrate round-robin: search starts at pointer rr_q; after a grant to port g, rr_q <= (g+1) mod NumPorts; with no grant rr_q holds.
REQ-012 SHALL compute word index = addr[log2(DataWidth/8) +: log2(Depth)]; higher address bits ignored (wrap-around aliasing), byte-offset bits ignored.
REQ-013 SHALL, on a granted write, update byte b of the indexed word iff strb[b]=1 at the granting clock edge; no response is issued (p_valid stays 0).
REQ-014 SHALL, on a granted read, drive p_valid[g]=1 and p.data[g]=word contents for exactly one cycle, the cycle after grant (latency 1); no p_ready exists, response is not held.
REQ-015 SHALL return write data to a read granted in any later cycle (write at cycle n, read granted n+1 returns new data).
REQ-016 SHALL drive p.data=0 on every port whose p_valid is 0.
REQ-017 SHALL ignore q.amo and q.user; requests with amo other than AMONone are treated as plain read/write.
REQ-018 SHALL accept back-to-back grants to the same port in consecutive cycles when no other port requests.
REQ-019 SHALL not require q_valid stability from initiators; a request dropped before grant is simply not served.
REQ-020 SHALL keep q_ready low on all ports while rst_ni is low.

Reset
REQ-021 SHALL, on rst_ni low, asynchronously clear rr_q to 0, all pending p_valid to 0, and all storage words to 0.
REQ-022 SHALL drop a read response pending when reset asserts mid-operation; no p_valid after reset release for pre-reset grants.
REQ-023 SHALL drive all outputs to 0 during reset.

Structure
REQ-024 SHALL place shared constants (word byte-offset width, index width helpers) in package snax_tcdm_responder_pkg; tcdm_req_t/tcdm_rsp_t stay parameter types, AMONone comes from reqrsp_pkg.
REQ-025 SHALL instantiate one sub-module snax_rr_arbiter (NumPorts requests, rr pointer, one-hot grant, grant index).
REQ-026 SHALL hold storage in a flop array; the response path is one register stage (valid vector, data, grant index).

Verification
REQ-027 Reset, then port 0 write addr 0x10 data 0x1122334455667788 strb 0xFF, next cycle port 0 read 0x10 -> p_valid[0]=1 two cycles after first grant with data 0x1122334455667788.
REQ-028 Write 0x0 data all-ones strb 0xFF, then write 0x0 data 0 strb 0x0F, read 0x0 -> data 0xFFFFFFFF00000000.
REQ-029 All 8 ports assert q_valid reads continuously from reset -> grants in order 0,1,...,7,0; each port gets exactly one p_valid per 8 cycles.
REQ-030 Write addr 0x0 data 0xAB, read addr Depth*8 (0x800) -> returns 0xAB (aliasing).
REQ-031 Read granted at cycle n, rst_ni pulsed low at cycle n+0.5 -> no p_valid at n+1, data reads 0 after release.
REQ-032 Port 3 issues write with p_valid monitored -> p_valid[3] never asserts; other ports' p.data remain 0.

Source files
------------

// File: rtl/snax_tcdm_responder_pkg.sv
// snax_tcdm_responder_pkg: shared widths, default TCDM request/response types and index helpers.
package snax_tcdm_responder_pkg;
  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefAddrWidth = 48;
  localparam int unsigned AmoWidth = 4;
  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic write;
    logic [AmoWidth-1:0] amo;
    logic [DefDataWidth-1:0] data;
    logic [DefDataWidth/8-1:0] strb;
    logic user;
  } snax_tcdm_req_chan_t;
  typedef struct packed {
    snax_tcdm_req_chan_t q;
    logic q_valid;
  } snax_tcdm_req_t;
  typedef struct packed {
    logic [DefDataWidth-1:0] data;
  } snax_tcdm_rsp_chan_t;
  typedef struct packed {
    snax_tcdm_rsp_chan_t p;
    logic p_valid;
    logic q_ready;
  } snax_tcdm_rsp_t;
  function automatic int unsigned offset_width(int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction
  function automatic int unsigned index_width(int unsigned n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/snax_tcdm_responder_if.sv
// snax_tcdm_responder_if: bundle of per-port TCDM request and response channels.
interface snax_tcdm_responder_if import snax_tcdm_responder_pkg::*; #(
  parameter int unsigned NumPorts = 8,
  parameter type tcdm_req_t = snax_tcdm_req_t,
  parameter type tcdm_rsp_t = snax_tcdm_rsp_t
) ();
  tcdm_req_t [NumPorts-1:0] req;
  tcdm_rsp_t [NumPorts-1:0] rsp;
  modport master (output req, input rsp);
  modport slave (input req, output rsp);
endinterface

// File: rtl/snax_rr_arbiter.sv
// snax_rr_arbiter: combinational round-robin pick starting the search at port rr.
module snax_rr_arbiter import snax_tcdm_responder_pkg::*; #(
  parameter int unsigned NumPorts = 8,
  localparam int unsigned PortW = index_width(NumPorts)
) (
  input  logic [NumPorts-1:0] req,
  input  logic [PortW-1:0]    rr,
  output logic [NumPorts-1:0] gnt,
  output logic                gnt_valid,
  output logic [PortW-1:0]    idx
);
  logic [PortW-1:0] pos;
  always_comb begin
    gnt = '0;
    gnt_valid = 1'b0;
    idx = '0;
    pos = '0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      pos = PortW'((32'(rr) + k) % NumPorts);
      if (!gnt_valid && req[pos]) begin
        gnt_valid = 1'b1;
        idx = pos;
        gnt[pos] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/snax_tcdm_responder.sv
// snax_tcdm_responder: multi-port TCDM memory, one round-robin grant per cycle, read latency 1.
module snax_tcdm_responder import snax_tcdm_responder_pkg::*; #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumPorts = 8,
  parameter int unsigned Depth = 256,
  parameter int unsigned TCDMAddrWidth = 48,
  parameter type tcdm_req_t = snax_tcdm_req_t,
  parameter type tcdm_rsp_t = snax_tcdm_rsp_t
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  tcdm_req_t [NumPorts-1:0] tcdm_req_i,
  output tcdm_rsp_t [NumPorts-1:0] tcdm_rsp_o
);
  localparam int unsigned OffW = offset_width(DataWidth);
  localparam int unsigned IdxW = index_width(Depth);
  localparam int unsigned PortW = index_width(NumPorts);
  localparam int unsigned NumBytes = DataWidth / 8;
  logic [NumPorts-1:0] req, gnt;
  logic gnt_valid;
  logic [PortW-1:0] gnt_idx, rr_q;
  tcdm_req_t sel;
  logic [TCDMAddrWidth-1:0] addr;
  logic [IdxW-1:0] word_idx;
  logic [DataWidth-1:0] mem_q [Depth];
  logic rsp_valid_q;
  logic [PortW-1:0] rsp_idx_q;
  logic [DataWidth-1:0] rsp_data_q;
  logic unused_bits;
  // Gating with rst_ni keeps every q_ready low for the whole reset window.
  for (genvar i = 0; i < NumPorts; i++) begin : g_port
    assign req[i] = rst_ni & tcdm_req_i[i].q_valid;
    assign tcdm_rsp_o[i].q_ready = gnt[i];
    assign tcdm_rsp_o[i].p_valid = rsp_valid_q && rsp_idx_q == PortW'(i);
    assign tcdm_rsp_o[i].p.data = (rsp_valid_q && rsp_idx_q == PortW'(i)) ? rsp_data_q : '0;
  end
  snax_rr_arbiter #(.NumPorts(NumPorts)) u_arb (
    .req(req),
    .rr(rr_q),
    .gnt(gnt),
    .gnt_valid(gnt_valid),
    .idx(gnt_idx)
  );
  assign sel = tcdm_req_i[gnt_idx];
  assign addr = sel.q.addr;
  assign word_idx = addr[OffW +: IdxW];
  assign unused_bits = ^sel;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q <= '0;
      rsp_data_q <= '0;
    end else begin
      rsp_valid_q <= gnt_valid & ~sel.q.write;
      rsp_idx_q <= gnt_idx;
      if (gnt_valid) rsp_data_q <= mem_q[word_idx];
      if (gnt_valid) rr_q <= (gnt_idx == PortW'(NumPorts - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < int'(Depth); d++) mem_q[d] <= '0;
    end else if (gnt_valid && sel.q.write) begin
      for (int b = 0; b < int'(NumBytes); b++)
        if (sel.q.strb[b]) mem_q[word_idx][b*8 +: 8] <= sel.q.data[b*8 +: 8];
    end
  end
endmodule

// File: tb/tb_snax_tcdm_responder.sv
// tb_snax_tcdm_responder: random and directed traffic checked against a behavioural memory model.
module tb_snax_tcdm_responder;
  import snax_tcdm_responder_pkg::*;
  localparam int NP = 8;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  snax_tcdm_responder_if #(.NumPorts(NP)) bus ();
  snax_tcdm_responder #(
    .DataWidth(64), .NumPorts(NP), .Depth(DEPTH), .TCDMAddrWidth(48),
    .tcdm_req_t(snax_tcdm_req_t), .tcdm_rsp_t(snax_tcdm_rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .tcdm_req_i(bus.req), .tcdm_rsp_o(bus.rsp)
  );
  logic [63:0] mem_m [DEPTH];
  int rr_m;
  bit pend_v;
  int pend_p;
  logic [63:0] pend_d;
  int checks = 0;
  int errors = 0;
  snax_tcdm_rsp_t [NP-1:0] obs;
  int glog [$];
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    rr_m = 0;
    pend_v = 1'b0;
  endtask
  // One clock: compare DUT against the model mid-cycle, then advance the model past the edge.
  task automatic tick();
    snax_tcdm_rsp_t e;
    snax_tcdm_req_t r;
    int g;
    logic [7:0] idx;
    @(negedge clk);
    obs = bus.rsp;
    if (!rst_n) begin
      model_reset();
      for (int i = 0; i < NP; i++) check($sformatf("reset port%0d", i), obs[i], '0);
    end else begin
      g = -1;
      for (int k = 0; k < NP; k++)
        if (g < 0 && bus.req[(rr_m + k) % NP].q_valid) g = (rr_m + k) % NP;
      for (int i = 0; i < NP; i++) begin
        e = '0;
        e.q_ready = (i == g);
        if (pend_v && pend_p == i) begin
          e.p_valid = 1'b1;
          e.p.data = pend_d;
        end
        check($sformatf("port%0d rsp", i), obs[i], e);
      end
      pend_v = 1'b0;
      if (g >= 0) begin
        glog.push_back(g);
        r = bus.req[g];
        idx = r.q.addr[10:3];
        if (r.q.write) begin
          for (int b = 0; b < 8; b++) if (r.q.strb[b]) mem_m[idx][8*b +: 8] = r.q.data[8*b +: 8];
        end else begin
          pend_v = 1'b1;
          pend_p = g;
          pend_d = mem_m[idx];
        end
        rr_m = (g + 1) % NP;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.req = '0;
  endtask
  task automatic set_req(input int p, input bit w, input logic [47:0] a, input logic [63:0] d, input logic [7:0] s);
    bus.req[p] = '0;
    bus.req[p].q_valid = 1'b1;
    bus.req[p].q.write = w;
    bus.req[p].q.addr = a;
    bus.req[p].q.data = d;
    bus.req[p].q.strb = s;
  endtask
  task automatic rand_req(input int p);
    logic [47:0] a;
    a = {16'($urandom), 32'($urandom)};
    a[10:3] = 8'($urandom_range(0, 15));
    bus.req[p].q.addr = a;
    bus.req[p].q.write = 1'($urandom);
    bus.req[p].q.amo = 4'($urandom);
    bus.req[p].q.data = {$urandom, $urandom};
    bus.req[p].q.strb = 8'($urandom);
    bus.req[p].q.user = 1'($urandom);
    bus.req[p].q_valid = $urandom_range(0, 99) < 40;
  endtask
  initial begin
    idle();
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    // write then read back on port 0
    set_req(0, 1'b1, 48'h10, 64'h1122334455667788, 8'hFF);
    tick();
    set_req(0, 1'b0, 48'h10, '0, '0);
    tick();
    idle();
    tick();
    check("rd_after_wr valid", obs[0].p_valid, 1);
    check("rd_after_wr data", obs[0].p.data, 64'h1122334455667788);
    // partial strobe merge
    set_req(0, 1'b1, 48'h0, '1, 8'hFF);
    tick();
    set_req(0, 1'b1, 48'h0, '0, 8'h0F);
    tick();
    set_req(0, 1'b0, 48'h0, '0, '0);
    tick();
    idle();
    tick();
    check("strobe merge data", obs[0].p.data, 64'hFFFFFFFF00000000);
    // index aliasing beyond Depth words
    set_req(2, 1'b1, 48'h0, 64'hAB, 8'hFF);
    tick();
    set_req(2, 1'b0, 48'h800, '0, '0);
    tick();
    idle();
    tick();
    check("alias data", obs[2].p.data, 64'hAB);
    // all ports reading continuously from reset
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 48'(p * 8), '0, '0);
    tick();
    glog.delete();
    rst_n = 1'b1;
    for (int c = 0; c < 17; c++) tick();
    check("grant log size", 128'(glog.size() >= 9), 1);
    for (int i = 0; i < 9 && i < glog.size(); i++) check($sformatf("grant order %0d", i), glog[i], i % NP);
    idle();
    tick();
    // reset asserted mid grant cycle drops the read
    set_req(0, 1'b1, 48'h20, 64'hDEAD, 8'hFF);
    tick();
    set_req(0, 1'b0, 48'h20, '0, '0);
    set_req(1, 1'b0, 48'h20, '0, '0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    tick();
    check("no rsp after reset", obs[0].p_valid, 0);
    set_req(0, 1'b0, 48'h20, '0, '0);
    tick();
    idle();
    tick();
    check("post reset valid", obs[0].p_valid, 1);
    check("post reset data", obs[0].p.data, 0);
    // writes never respond
    for (int c = 0; c < 6; c++) begin
      set_req(3, 1'b1, 48'(c * 8), {$urandom, $urandom}, 8'hFF);
      tick();
      check($sformatf("write no p_valid %0d", c), obs[3].p_valid, 0);
    end
    idle();
    tick();
    check("write port data zero", obs[3].p.data, 0);
    // randomized traffic with occasional reset pulses
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < NP; p++) rand_req(p);
      rst_n = $urandom_range(0, 199) != 0;
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
